// File: rtl/prng_byte_stream.sv
// Random-byte buffer between the PRNG block source and the sampler datapath.
// Caches one PRNG block, feeds it slice by slice into a circular byte buffer, serves variable-length reads.
module prng_byte_stream #(
  parameter int BLK_W     = 512,
  parameter int SLICE_W   = 128,
  parameter int BUF_BYTES = 32,
  parameter int MAX_RD    = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             init,
  output logic                             blk_req,
  input  logic                             blk_valid,
  input  logic [BLK_W-1:0]                 blk_data,
  input  logic                             rd_req,
  input  logic [$clog2(MAX_RD+1)-1:0]      rd_len,
  output logic                             rd_ready,
  output logic [8*MAX_RD-1:0]              rd_data,
  output logic [$clog2(BUF_BYTES+1)-1:0]   level,
  output logic                             full,
  output logic                             empty
);

  localparam int SLICE_BYTES = SLICE_W / 8;
  localparam int NSLICE      = BLK_W / SLICE_W;
  localparam int PTR_W       = $clog2(BUF_BYTES);
  localparam int SIDX_W      = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int LEN_W       = $clog2(MAX_RD + 1);
  localparam int LVL_W       = $clog2(BUF_BYTES + 1);

  logic [7:0]         mem [BUF_BYTES];
  logic [BLK_W-1:0]   blk;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [SIDX_W-1:0]  sidx;
  logic               blk_vld;

  logic               xfer;
  logic               refill;
  logic               rd_fire;
  logic               last_slice;
  logic [SLICE_W-1:0] slice;
  logic [LVL_W-1:0]   level_next;

  assign xfer       = blk_req & blk_valid;
  // Only refill when a whole slice fits, so unread bytes are never overwritten.
  assign refill     = blk_vld & (level <= LVL_W'(BUF_BYTES - SLICE_BYTES));
  assign rd_ready   = (level >= LVL_W'(rd_len));
  assign rd_fire    = rd_req & rd_ready;
  assign last_slice = (sidx == SIDX_W'(NSLICE - 1));
  assign slice      = blk[sidx*SLICE_W +: SLICE_W];
  assign level_next = level
                    + (refill  ? LVL_W'(SLICE_BYTES) : LVL_W'(0))
                    - (rd_fire ? LVL_W'(rd_len)      : LVL_W'(0));

  assign full  = (level == LVL_W'(BUF_BYTES));
  assign empty = (level == LVL_W'(0));

  generate
    for (genvar gi = 0; gi < MAX_RD; gi++) begin : g_rd
      assign rd_data[8*gi +: 8] = (LEN_W'(gi) < rd_len) ? mem[rd_ptr + PTR_W'(gi)] : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_BYTES; i++) mem[i] <= 8'h00;
    end else if (refill && !init) begin
      for (int j = 0; j < SLICE_BYTES; j++) mem[wr_ptr + PTR_W'(j)] <= slice[8*j +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk     <= '0;
      blk_vld <= 1'b0;
      blk_req <= 1'b0;
      sidx    <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level   <= '0;
    end else if (init) begin
      blk_vld <= 1'b0;
      blk_req <= 1'b0;
      sidx    <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level   <= '0;
    end else begin
      // An outstanding request is held until served even if en drops.
      blk_req <= (en | blk_req) & ~blk_vld & ~xfer;
      if (xfer) begin
        blk     <= blk_data;
        blk_vld <= 1'b1;
        sidx    <= '0;
      end else if (refill) begin
        sidx <= last_slice ? '0 : sidx + 1'b1;
        if (last_slice) blk_vld <= 1'b0;
      end
      if (refill)  wr_ptr <= wr_ptr + PTR_W'(SLICE_BYTES);
      if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(rd_len);
      level <= level_next;
    end
  end

endmodule

// File: tb/tb_prng_byte_stream.sv
// Directed bench for prng_byte_stream: reads are scoreboarded through a queue,
// status outputs are compared at fixed points of the sequence.
module tb_prng_byte_stream;
  localparam int BLK_W     = 512;
  localparam int SLICE_W   = 128;
  localparam int BUF_BYTES = 32;
  localparam int MAX_RD    = 10;
  localparam int LEN_W     = $clog2(MAX_RD + 1);
  localparam int LVL_W     = $clog2(BUF_BYTES + 1);
  localparam int DW        = 8 * MAX_RD;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             init;
  logic             blk_req;
  logic             blk_valid;
  logic [BLK_W-1:0] blk_data;
  logic             rd_req;
  logic [LEN_W-1:0] rd_len;
  logic             rd_ready;
  logic [DW-1:0]    rd_data;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;

  always #5 clk = ~clk;

  prng_byte_stream #(
    .BLK_W(BLK_W), .SLICE_W(SLICE_W), .BUF_BYTES(BUF_BYTES), .MAX_RD(MAX_RD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .init(init),
    .blk_req(blk_req), .blk_valid(blk_valid), .blk_data(blk_data),
    .rd_req(rd_req), .rd_len(rd_len), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .full(full), .empty(empty)
  );

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_reads  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a read whose expected bytes are consecutive values starting at first.
  task automatic issue_rd(input logic [7:0] first, input int len);
    logic [DW-1:0] e;
    e = '0;
    for (int i = 0; i < len; i++) e[8*i +: 8] = first + 8'(i);
    exp_q.push_back(e);
    rd_len = LEN_W'(len);
    rd_req = 1'b1;
  endtask

  function automatic logic [BLK_W-1:0] make_blk(input logic [7:0] base);
    logic [BLK_W-1:0] b;
    for (int i = 0; i < BLK_W/8; i++) b[8*i +: 8] = base + 8'(i);
    return b;
  endfunction

  // Monitor: every accepted read must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && rd_req && rd_ready) begin
      n_checks++;
      n_reads++;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_data: unexpected read got %0h expected none", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data === mon_exp) begin
          n_pass++;
          $display("read %0d len %0d data %0h", n_reads, rd_len, rd_data);
        end else begin
          $display("FAIL rd_data read %0d: got %0h expected %0h", n_reads, rd_data, mon_exp);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; init = 1'b0; blk_valid = 1'b0; blk_data = '0;
    rd_req = 1'b0; rd_len = '0;
    #12;
    chk("rst_level", DW'(level), DW'(0));
    chk("rst_empty", DW'(empty), DW'(1));
    chk("rst_full", DW'(full), DW'(0));
    chk("rst_blk_req", DW'(blk_req), DW'(0));
    chk("rst_rd_data", rd_data, DW'(0));
    chk("rst_ready_len0", DW'(rd_ready), DW'(1));
    rd_len = LEN_W'(1);
    #1;
    chk("rst_ready_len1", DW'(rd_ready), DW'(0));
    rd_len = '0;

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    chk("blk_req_rise", DW'(blk_req), DW'(1));
    blk_valid = 1'b1;
    blk_data  = make_blk(8'h00);
    tick();
    blk_valid = 1'b0;
    chk("blk_req_after_xfer", DW'(blk_req), DW'(0));
    chk("level_xfer", DW'(level), DW'(0));
    tick();
    chk("level_slice0", DW'(level), DW'(16));
    chk("empty_slice0", DW'(empty), DW'(0));
    tick();
    chk("level_slice1", DW'(level), DW'(32));
    chk("full_slice1", DW'(full), DW'(1));
    tick();
    chk("level_hold_full", DW'(level), DW'(32));
    chk("blk_req_busy", DW'(blk_req), DW'(0));

    issue_rd(8'h00, 10); tick(); chk("level_rd1", DW'(level), DW'(22));
    issue_rd(8'h0A, 10); tick(); chk("level_rd2", DW'(level), DW'(12));
    issue_rd(8'h14, 10); tick(); chk("level_rd3_refill", DW'(level), DW'(18));
    issue_rd(8'h1E, 10); tick(); chk("level_rd4_wrap", DW'(level), DW'(8));
    rd_req = 1'b0;
    tick();
    chk("level_slice3", DW'(level), DW'(24));
    chk("blk_req_not_yet", DW'(blk_req), DW'(0));
    tick();
    chk("blk_req_drained", DW'(blk_req), DW'(1));

    issue_rd(8'h28, 10); tick(); chk("level_rd5", DW'(level), DW'(14));
    issue_rd(8'h32, 9);  tick(); chk("level_rd6", DW'(level), DW'(5));
    rd_len = LEN_W'(10);
    #1;
    chk("stall_ready", DW'(rd_ready), DW'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_level", DW'(level), DW'(5));
      chk("stall_blk_req", DW'(blk_req), DW'(1));
    end
    issue_rd(8'h3B, 5);
    #1;
    chk("ready_len5", DW'(rd_ready), DW'(1));
    tick();
    rd_req = 1'b0;
    chk("level_empty", DW'(level), DW'(0));
    chk("empty_flag", DW'(empty), DW'(1));

    blk_valid = 1'b1;
    blk_data  = make_blk(8'h40);
    tick();
    blk_valid = 1'b0;
    chk("blk_req_xfer2", DW'(blk_req), DW'(0));
    tick(); chk("level_b2_slice0", DW'(level), DW'(16));
    issue_rd(8'h40, 10); tick(); chk("level_refill_and_rd", DW'(level), DW'(22));
    issue_rd(8'h4A, 10); tick(); chk("level_b2_rd2", DW'(level), DW'(12));
    issue_rd(8'h54, 10); tick(); chk("level_b2_rd3", DW'(level), DW'(18));
    issue_rd(8'h5E, 2);  tick(); chk("level_b2_rd4", DW'(level), DW'(16));
    rd_req = 1'b0;
    tick(); chk("level_b2_slice3", DW'(level), DW'(32));
    tick(); chk("blk_req_b2_drained", DW'(blk_req), DW'(1));
    issue_rd(8'h60, 10); tick(); chk("level_b2_rd5", DW'(level), DW'(22));
    issue_rd(8'h6A, 2);  tick(); chk("level_pre_init", DW'(level), DW'(20));
    chk("blk_req_pre_init", DW'(blk_req), DW'(1));

    rd_req    = 1'b0;
    init      = 1'b1;
    blk_valid = 1'b1;
    blk_data  = make_blk(8'h80);
    tick();
    init      = 1'b0;
    blk_valid = 1'b0;
    chk("init_level", DW'(level), DW'(0));
    chk("init_empty", DW'(empty), DW'(1));
    chk("init_blk_req", DW'(blk_req), DW'(0));
    tick();
    chk("post_init_blk_req", DW'(blk_req), DW'(1));
    chk("post_init_level", DW'(level), DW'(0));
    tick();
    chk("no_block_loaded", DW'(level), DW'(0));
    rd_len = LEN_W'(1);
    #1;
    chk("init_ready_len1", DW'(rd_ready), DW'(0));
    chk("reads_consumed", DW'(exp_q.size()), DW'(0));

    rd_len = LEN_W'(10);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_blk_req", DW'(blk_req), DW'(0));
    chk("async_rst_rd_data", rd_data, DW'(0));
    chk("async_rst_empty", DW'(empty), DW'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
